ble_rx_dma: RTL

// - Sits between uart_rx (BLE link, rx_done/data) and the servant_ram Wishbone port.
// - Buffers received bytes in a small FIFO and writes each one into a RAM ring region [ADR_LL..ADR_UL].
// - Arbitrates the single RAM port between the serv CPU master and this DMA writer, so no byte is lost
//   or overwritten while the CPU is mid-transaction.

---
 rtl/ble_rx_dma_pkg.sv | 20 ++
 rtl/ble_rx_dma_fifo.sv | 62 ++++++
 rtl/ble_rx_dma.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ble_rx_dma_pkg.sv
// Shared types and memory-map defaults for the BLE receive DMA slice.
package ble_rx_dma_pkg;

  localparam logic [31:0] ADR_LL_DEF = 32'h00C00000;
  localparam logic [31:0] ADR_UL_DEF = 32'h00C0FFFF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_e;

  // Ring successor of a byte address inside [ll..ul].
  function automatic logic [31:0] ring_next(input logic [31:0] adr,
                                            input logic [31:0] ll,
                                            input logic [31:0] ul);
    return (adr == ul) ? ll : adr + 32'd1;
  endfunction

endpackage

// File: rtl/ble_rx_dma_fifo.sv
// Byte FIFO with registered occupancy count; storage is not reset.
module ble_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ble_rx_dma.sv
// BLE receive DMA: buffers UART bytes and writes them into a RAM ring,
// sharing the single RAM Wishbone port with the CPU by round-robin.
module ble_rx_dma
  import ble_rx_dma_pkg::*;
#(
  parameter int          DEPTH  = 16,
  parameter logic [31:0] ADR_LL = ADR_LL_DEF,
  parameter logic [31:0] ADR_UL = ADR_UL_DEF
) (
  input  logic                   i_wb_clk,
  input  logic                   i_wb_rst,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_ovf_clr,
  input  logic [31:0]            i_cpu_adr,
  input  logic                   i_cpu_cyc,
  input  logic                   i_cpu_we,
  input  logic [3:0]             i_cpu_sel,
  input  logic [31:0]            i_cpu_dat,
  output logic [31:0]            o_cpu_rdt,
  output logic                   o_cpu_ack,
  output logic [31:0]            o_mem_adr,
  output logic                   o_mem_cyc,
  output logic                   o_mem_we,
  output logic [3:0]             o_mem_sel,
  output logic [31:0]            o_mem_dat,
  input  logic [31:0]            i_mem_rdt,
  input  logic                   i_mem_ack,
  output logic [31:0]            o_wr_adr,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow
);

  arb_state_e  state_q, state_d;
  logic        last_dma_q, last_dma_d;
  logic [31:0] wr_adr_q, wr_adr_d;
  logic        ovf_q, ovf_d;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_head;

  assign fifo_pop = (state_q == ARB_DMA) && i_mem_ack;

  ble_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_wb_clk),
    .rst   (i_wb_rst),
    .push  (i_rx_valid),
    .pop   (fifo_pop),
    .din   (i_rx_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

  // Every grant returns through IDLE, so i_mem_ack is low when the next one starts.
  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    wr_adr_d   = wr_adr_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_cpu_cyc && (fifo_empty || last_dma_q)) state_d = ARB_CPU;
        else if (!fifo_empty)                        state_d = ARB_DMA;
      end
      ARB_CPU: begin
        if (i_mem_ack) begin
          state_d    = ARB_IDLE;
          last_dma_d = 1'b0;
        end
      end
      ARB_DMA: begin
        if (i_mem_ack) begin
          state_d    = ARB_IDLE;
          last_dma_d = 1'b1;
          wr_adr_d   = ring_next(wr_adr_q, ADR_LL, ADR_UL);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (i_rx_valid && fifo_full) ovf_d = 1'b1;
    else if (i_ovf_clr)          ovf_d = 1'b0;
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q    <= ARB_IDLE;
      last_dma_q <= 1'b1;
      wr_adr_q   <= ADR_LL;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      wr_adr_q   <= wr_adr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    o_mem_adr = '0;
    o_mem_cyc = 1'b0;
    o_mem_we  = 1'b0;
    o_mem_sel = '0;
    o_mem_dat = '0;
    o_cpu_ack = 1'b0;
    case (state_q)
      ARB_CPU: begin
        o_mem_adr = i_cpu_adr;
        o_mem_cyc = i_cpu_cyc;
        o_mem_we  = i_cpu_we;
        o_mem_sel = i_cpu_sel;
        o_mem_dat = i_cpu_dat;
        o_cpu_ack = i_mem_ack;
      end
      ARB_DMA: begin
        o_mem_adr = {wr_adr_q[31:2], 2'b00};
        o_mem_cyc = 1'b1;
        o_mem_we  = 1'b1;
        o_mem_sel = 4'b0001 << wr_adr_q[1:0];
        o_mem_dat = {4{fifo_head}};
      end
      default: ;
    endcase
  end

  assign o_cpu_rdt  = i_mem_rdt;
  assign o_wr_adr   = wr_adr_q;
  assign o_overflow = ovf_q;

endmodule
